// File: rtl/sha2_pkg.sv
// SHA-2 shared types, round constants, initial hash values and
// the Sigma/sigma/Ch/Maj functions for 32- and 64-bit words.
package sha2_pkg;

    typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

    localparam logic [31:0] K32 [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [63:0] K64 [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f,
        64'he9b5dba58189dbbc, 64'h3956c25bf348b538, 64'h59f111f1b605d019,
        64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118, 64'hd807aa98a3030242,
        64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235,
        64'hc19bf174cf692694, 64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
        64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65, 64'h2de92c6f592b0275,
        64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f,
        64'hbf597fc7beef0ee4, 64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
        64'h06ca6351e003826f, 64'h142929670a0e6e70, 64'h27b70a8546d22ffc,
        64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6,
        64'h92722c851482353b, 64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
        64'hc24b8b70d0f89791, 64'hc76c51a30654be30, 64'hd192e819d6ef5218,
        64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99,
        64'h34b0bcb5e19b48a8, 64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
        64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3, 64'h748f82ee5defb2fc,
        64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915,
        64'hc67178f2e372532b, 64'hca273eceea26619c, 64'hd186b8c721c0c207,
        64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178, 64'h06f067aa72176fba,
        64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc,
        64'h431d67c49c100d4c, 64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
        64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    localparam logic [255:0] IV224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [511:0] IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507,
        64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511,
        64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b,
        64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f,
        64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [511:0] IV512_256 = {
        64'h22312194fc2bf72c, 64'h9f555fa3c84c64c2,
        64'h2393b86b6f53b151, 64'h963877195940eabd,
        64'h96283ee2a88effe3, 64'hbe5e1e2553863992,
        64'h2b0199fc2c85b8aa, 64'h0eb72ddc81c52ca2};
    localparam logic [511:0] IV512_224 = {
        64'h8c3d37c819544da2, 64'h73e1996689dcd4d6,
        64'h1dfab7ae32ff9c82, 64'h679dd514582f9fcf,
        64'h0f6d2b697bd44da8, 64'h77e36f7304c48942,
        64'h3f9d85a86a1d36c8, 64'h1112e6ad91d692a1};

    function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [31:0] bsig0_32(input logic [31:0] x);
        return ror32(x, 2) ^ ror32(x, 13) ^ ror32(x, 22);
    endfunction

    function automatic logic [31:0] bsig1_32(input logic [31:0] x);
        return ror32(x, 6) ^ ror32(x, 11) ^ ror32(x, 25);
    endfunction

    function automatic logic [31:0] ssig0_32(input logic [31:0] x);
        return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1_32(input logic [31:0] x);
        return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [63:0] bsig0_64(input logic [63:0] x);
        return ror64(x, 28) ^ ror64(x, 34) ^ ror64(x, 39);
    endfunction

    function automatic logic [63:0] bsig1_64(input logic [63:0] x);
        return ror64(x, 14) ^ ror64(x, 18) ^ ror64(x, 41);
    endfunction

    function automatic logic [63:0] ssig0_64(input logic [63:0] x);
        return ror64(x, 1) ^ ror64(x, 8) ^ (x >> 7);
    endfunction

    function automatic logic [63:0] ssig1_64(input logic [63:0] x);
        return ror64(x, 19) ^ ror64(x, 61) ^ (x >> 6);
    endfunction

    function automatic logic [31:0] ch_32(input logic [31:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj_32(input logic [31:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

    function automatic logic [63:0] ch_64(input logic [63:0] e, f, g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [63:0] maj_64(input logic [63:0] a, b, c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha2_schedule.sv
// SHA-2 message schedule: 16-word rolling window, win[0] is W[t].
// Each shift appends W[t+16] and drops W[t].
module sha2_schedule #(
    parameter int WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [16*WORD_W-1:0] data,
    output logic [WORD_W-1:0]    w
);
    import sha2_pkg::*;

    logic [WORD_W-1:0] win [16];
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;
    logic [WORD_W-1:0] nxt;

    if (WORD_W == 64) begin : g_64
        assign s0 = ssig0_64(win[1]);
        assign s1 = ssig1_64(win[14]);
    end else begin : g_32
        assign s0 = ssig0_32(win[1]);
        assign s1 = ssig1_32(win[14]);
    end

    assign nxt = s1 + win[9] + s0 + win[0];
    assign w   = win[0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 16; i++) win[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++)
                win[i] <= data[(15-i)*WORD_W +: WORD_W];
        end else if (shift) begin
            for (int i = 0; i < 15; i++) win[i] <= win[i+1];
            win[15] <= nxt;
        end
    end

endmodule

// File: rtl/sha2_core.sv
// Iterative SHA-2 compression core, one round per cycle.
// WORD_W=32 gives SHA-224/256, WORD_W=64 the SHA-384/512 family.
module sha2_core #(
    parameter int WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*WORD_W-1:0] in_data,
    input  logic                 in_first,
    input  logic [1:0]           in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*WORD_W-1:0]  out_hash
);
    import sha2_pkg::*;

    localparam int ROUNDS = (WORD_W == 64) ? 80 : 64;
    localparam int CW = $clog2(ROUNDS);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WORD_W-1:0] hr [8];
    logic [WORD_W-1:0] v [8];
    logic [WORD_W-1:0] kt, wt, bs0, bs1, chv, mjv, t1, t2;
    logic [8*WORD_W-1:0] iv;
    logic              accept;

    assign accept = in_valid && in_ready;

    if (WORD_W == 64) begin : g_64
        assign kt  = K64[cnt];
        assign bs0 = bsig0_64(v[0]);
        assign bs1 = bsig1_64(v[4]);
        assign chv = ch_64(v[4], v[5], v[6]);
        assign mjv = maj_64(v[0], v[1], v[2]);
        always_comb begin
            case (in_mode)
                2'd0:    iv = IV384;
                2'd1:    iv = IV512;
                2'd2:    iv = IV512_256;
                default: iv = IV512_224;
            endcase
        end
    end else begin : g_32
        assign kt  = K32[cnt];
        assign bs0 = bsig0_32(v[0]);
        assign bs1 = bsig1_32(v[4]);
        assign chv = ch_32(v[4], v[5], v[6]);
        assign mjv = maj_32(v[0], v[1], v[2]);
        assign iv  = (in_mode == 2'd0) ? IV224 : IV256;
    end

    assign t1 = v[7] + bs1 + chv + kt + wt;
    assign t2 = bs0 + mjv;

    sha2_schedule #(.WORD_W(WORD_W)) u_sched (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (state == ROUND),
        .data  (in_data),
        .w     (wt)
    );

    for (genvar i = 0; i < 8; i++) begin : g_out
        assign out_hash[(7-i)*WORD_W +: WORD_W] = hr[i];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            cnt       <= '0;
            for (int i = 0; i < 8; i++) begin
                hr[i] <= '0;
                v[i]  <= '0;
            end
        end else begin
            unique case (state)
                IDLE: if (in_valid) begin
                    for (int i = 0; i < 8; i++) begin
                        if (in_first) begin
                            hr[i] <= iv[(7-i)*WORD_W +: WORD_W];
                            v[i]  <= iv[(7-i)*WORD_W +: WORD_W];
                        end else begin
                            v[i]  <= hr[i];
                        end
                    end
                    cnt      <= '0;
                    in_ready <= 1'b0;
                    state    <= ROUND;
                end
                ROUND: begin
                    v[0] <= t1 + t2;
                    v[1] <= v[0];
                    v[2] <= v[1];
                    v[3] <= v[2];
                    v[4] <= v[3] + t1;
                    v[5] <= v[4];
                    v[6] <= v[5];
                    v[7] <= v[6];
                    if (cnt == LAST) state <= FINAL;
                    else             cnt   <= cnt + 1'b1;
                end
                FINAL: begin
                    for (int i = 0; i < 8; i++) hr[i] <= hr[i] + v[i];
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha2_core.sv
// Bench for sha2_core: known SHA-2 vectors plus random blocks
// checked against a plain SHA-256 compression model.
module tb_sha2_core;

    localparam logic [511:0] ABC32 = {32'h61626380, {14{32'h0}}, 32'h18};
    localparam logic [511:0] TWO1 = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO2 = {{15{32'h0}}, 32'h1c0};
    localparam logic [255:0] ABC256 =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [223:0] ABC224 =
        224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;
    localparam logic [255:0] TWO256 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] H224 = {
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    localparam logic [255:0] H256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    logic         v32, rdy32, fst32, ov32, ordy32;
    logic [1:0]   mode32;
    logic [511:0] dat32;
    logic [255:0] hash32;

    logic          v64, rdy64, fst64, ov64, ordy64;
    logic [1:0]    mode64;
    logic [1023:0] dat64;
    logic [511:0]  hash64;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha2_core #(.WORD_W(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
        .in_data(dat32), .in_first(fst32), .in_mode(mode32),
        .out_valid(ov32), .out_ready(ordy32), .out_hash(hash32));

    sha2_core #(.WORD_W(64)) dut64 (
        .clk(clk), .rst(rst), .in_valid(v64), .in_ready(rdy64),
        .in_data(dat64), .in_first(fst64), .in_mode(mode64),
        .out_valid(ov64), .out_ready(ordy64), .out_hash(hash64));

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref256(input logic [255:0] hin,
                                            input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] s [8];
        logic [31:0] t1, t2, x0, x1;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            x0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            x1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = x1 + w[i-7] + x0 + w[i-16];
        end
        for (int i = 0; i < 8; i++) s[i] = hin[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25))
               + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
            t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22))
               + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
            s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++)
            r[255-32*i -: 32] = hin[255-32*i -: 32] + s[i];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send32(input logic [511:0] d, input logic f,
                          input logic [1:0] m, output int lat);
        int n;
        int t0;
        n = 0;
        while (rdy32 !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        dat32 = d; fst32 = f; mode32 = m; v32 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        v32 = 1'b0; fst32 = 1'b0;
        n = 0;
        while (ov32 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        lat = cyc - t0;
    endtask

    task automatic rel32();
        ordy32 = 1'b1;
        @(negedge clk);
        ordy32 = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int t0;
        logic [511:0] blk;
        logic [255:0] h_ref;
        logic f;
        logic [1:0] m;

        rst = 1'b0;
        v32 = 0; fst32 = 0; mode32 = 0; dat32 = '0; ordy32 = 0;
        v64 = 0; fst64 = 0; mode64 = 0; dat64 = '0; ordy64 = 0;
        repeat (3) @(negedge clk);
        chk("rst_ready32", rdy32, 1'b1);
        chk("rst_valid32", ov32, 1'b0);
        chk("rst_hash32", hash32, '0);
        chk("rst_ready64", rdy64, 1'b1);
        chk("rst_valid64", ov64, 1'b0);
        chk("rst_hash64", hash64, '0);
        rst = 1'b1;
        @(negedge clk);

        send32(ABC32, 1'b1, 2'd1, lat);
        chk("abc256_lat", lat, 66);
        chk("abc256", hash32, ABC256);
        rel32();
        chk("idle_after_rel", rdy32, 1'b1);

        send32(ABC32, 1'b1, 2'd0, lat);
        chk("abc224", hash32[255:32], ABC224);
        rel32();

        send32(ABC32, 1'b1, 2'd3, lat);
        chk("abc_mode3", hash32, ABC256);
        rel32();

        send32(TWO1, 1'b1, 2'd1, lat);
        rel32();
        send32(TWO2, 1'b0, 2'd0, lat);
        chk("two_block", hash32, TWO256);
        rel32();

        send32(ABC32, 1'b1, 2'd1, lat);
        for (int k = 0; k < 10; k++) begin
            chk("hold_valid", ov32, 1'b1);
            chk("hold_hash", hash32, ABC256);
            chk("hold_ready", rdy32, 1'b0);
            if (k == 5) begin
                v32 = 1'b1; fst32 = 1'b1; mode32 = 2'd0; dat32 = TWO1;
            end else begin
                v32 = 1'b0; fst32 = 1'b0;
            end
            @(negedge clk);
        end
        v32 = 1'b0; fst32 = 1'b0;
        rel32();
        chk("rel_valid", ov32, 1'b0);
        chk("rel_ready", rdy32, 1'b1);
        chk("rel_hash", hash32, ABC256);

        dat64 = {64'h6162638000000000, {14{64'h0}}, 64'h18};
        fst64 = 1'b1; mode64 = 2'd1; v64 = 1'b1;
        t0 = cyc;
        @(negedge clk);
        v64 = 1'b0; fst64 = 1'b0;
        n = 0;
        while (ov64 !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("abc512_lat", cyc - t0, 82);
        chk("abc512_h0", hash64[511:448], 64'hddaf35a193617aba);
        chk("abc512_h7", hash64[31:0], 32'ha54ca49f);
        ordy64 = 1'b1;
        @(negedge clk);
        ordy64 = 1'b0;
        chk("idle64", rdy64, 1'b1);

        dat32 = TWO1; fst32 = 1'b1; mode32 = 2'd1; v32 = 1'b1;
        @(negedge clk);
        v32 = 1'b0; fst32 = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_ready", rdy32, 1'b1);
        chk("abort_valid", ov32, 1'b0);
        chk("abort_hash", hash32, '0);
        send32(ABC32, 1'b1, 2'd1, lat);
        chk("abort_abc", hash32, ABC256);
        chk("abort_lat", lat, 66);
        rel32();

        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        h_ref = '0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 16; j++) blk[511-32*j -: 32] = $urandom;
            f = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            m = 2'($urandom_range(0, 3));
            if (f) h_ref = (m == 2'd0) ? H224 : H256;
            h_ref = ref256(h_ref, blk);
            send32(blk, f, m, lat);
            chk("rand_hash", hash32, h_ref);
            rel32();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
